// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int unsigned DefAw = 5;
  localparam int unsigned DefDw = 32;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// In-order instruction queue; flush takes priority over push and pop.
module inst_fetch_ctrl_fetch_queue #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the instruction ROM and queues words for decode.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt_req,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_inst,
  output logic [AW-1:0] out_pc,
  output logic          busy,
  output logic [CW-1:0] fetch_count
);

  localparam int unsigned QCntW = $clog2(DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] fetch_count_q, fetch_count_d;

  logic             push, pop;
  logic             q_empty, q_full;
  logic [QCntW-1:0] q_count;
  logic [DW+AW-1:0] q_head;

  // A redirect hides the head so the flushed word can never be consumed.
  assign out_valid = !q_empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = (state_q == StRun) && !redirect_valid && (!q_full || pop);

  inst_fetch_ctrl_fetch_queue #(
    .Width (DW + AW),
    .Depth (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ({rom_inst, pc_q}),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (redirect_valid || q_empty || (q_count == QCntW'(1) && pop)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + AW'(1);
    end
    if (push) begin
      fetch_count_d = fetch_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign out_inst    = q_empty ? DW'(Nop) : q_head[AW +: DW];
  assign out_pc      = q_empty ? '0 : q_head[AW-1:0];
  assign busy        = (state_q != StIdle);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: stimulus queues expected pops, a monitor checks them.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [4:0]  out_pc;
  logic        busy;
  logic [15:0] fetch_count;

  logic [31:0] rom [32];

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .busy           (busy),
    .fetch_count    (fetch_count)
  );

  assign rom_inst = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_pop(input logic [4:0] pc, input logic [31:0] inst);
    sb.push_back({pc, inst});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0d inst %h, required no pop", out_pc, out_inst);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_pc", {27'd0, out_pc}, {27'd0, mon_e.pc});
        chk("pop_inst", out_inst, mon_e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | i;
    rom[0]  = 32'h0000_0000;
    rom[1]  = 32'h0043_0820;
    rom[2]  = 32'h0064_1022;
    rom[3]  = 32'h0085_1823;
    rom[8]  = 32'h8ce8_0002;
    rom[12] = 32'h0800_0008;
    rom[31] = 32'h0000_0000;

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
    chk("rst_out_pc", {27'd0, out_pc}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);

    // Basic fetch, then reset with a full queue.
    step();  // cycle 0
    start = 1'b1; out_ready = 1'b1;
    expect_pop(5'd0, 32'h0000_0000);
    expect_pop(5'd1, 32'h0043_0820);
    expect_pop(5'd2, 32'h0064_1022);
    expect_pop(5'd3, 32'h0085_1823);
    step();  // cycle 1
    start = 1'b0;
    @(negedge clk);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("first_latency_valid", {31'd0, out_valid}, 32'd0);
    repeat (5) step();  // cycle 6
    out_ready = 1'b0;
    step();  // cycle 7
    @(negedge clk);
    chk("full_fetch_count", {16'd0, fetch_count}, 32'd6);
    chk("full_rom_addr", {27'd0, rom_addr}, 32'd6);
    chk("full_head_pc", {27'd0, out_pc}, 32'd4);
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();  // new cycle 0
    rst = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("midrst_fetch_count", {16'd0, fetch_count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    for (int p = 0; p < 12; p++) expect_pop(5'(p), rom[p]);
    expect_pop(5'd8, 32'h8ce8_0002);
    expect_pop(5'd9, rom[9]);
    expect_pop(5'd31, 32'h0000_0000);
    expect_pop(5'd0, 32'h0000_0000);
    expect_pop(5'd1, 32'h0043_0820);
    expect_pop(5'd2, 32'h0064_1022);
    expect_pop(5'd3, 32'h0085_1823);
    expect_pop(5'd4, rom[4]);
    expect_pop(5'd5, rom[5]);

    // Backpressure.
    step();  // cycle 1
    start = 1'b0;
    step();  // cycle 2
    out_ready = 1'b0;
    step();  // cycle 3
    @(negedge clk);
    chk("bp_rom_addr", {27'd0, rom_addr}, 32'd2);
    chk("bp_fetch_count", {16'd0, fetch_count}, 32'd2);
    chk("bp_head_pc", {27'd0, out_pc}, 32'd0);
    step();  // cycle 4
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    step();  // cycle 5
    @(negedge clk);
    chk("no_gap_valid", {31'd0, out_valid}, 32'd1);
    chk("no_gap_head_pc", {27'd0, out_pc}, 32'd1);

    // Redirect while head is pc 12.
    repeat (11) step();  // cycle 16
    redirect_valid = 1'b1; redirect_pc = 5'd8;
    @(negedge clk);
    chk("redir_valid_forced", {31'd0, out_valid}, 32'd0);
    chk("redir_head_pc", {27'd0, out_pc}, 32'd12);
    chk("redir_head_inst", out_inst, 32'h0800_0008);
    step();  // cycle 17
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_q_empty", {31'd0, out_valid}, 32'd0);
    chk("redir_rom_addr", {27'd0, rom_addr}, 32'd8);

    // Wrap from pc 31.
    repeat (3) step();  // cycle 20
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    step();  // cycle 21
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_rom_addr31", {27'd0, rom_addr}, 32'd31);
    step();  // cycle 22
    @(negedge clk);
    chk("wrap_rom_addr0", {27'd0, rom_addr}, 32'd0);

    // Halt and drain.
    repeat (3) step();  // cycle 25
    out_ready = 1'b0;
    step();  // cycle 26
    halt_req = 1'b1;
    step();  // cycle 27
    halt_req = 1'b0;
    @(negedge clk);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_rom_addr", {27'd0, rom_addr}, 32'd4);
    chk("drain_fetch_count", {16'd0, fetch_count}, 32'd22);
    chk("drain_head_pc", {27'd0, out_pc}, 32'd2);
    step();  // cycle 28
    @(negedge clk);
    chk("drain_no_fetch", {27'd0, rom_addr}, 32'd4);
    step();  // cycle 29
    out_ready = 1'b1;
    repeat (2) step();  // cycle 31
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    start = 1'b1;
    step();  // cycle 32
    start = 1'b0;
    @(negedge clk);
    chk("resume_busy", {31'd0, busy}, 32'd1);
    chk("resume_latency_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) step();  // cycle 35
    out_ready = 1'b0;
    step();  // cycle 36
    @(negedge clk);
    chk("final_fetch_count", {16'd0, fetch_count}, 32'd26);
    chk("final_rom_addr", {27'd0, rom_addr}, 32'd8);
    repeat (2) step();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
